instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  ADDR_WIDTH, 64, PC width.
  INSTR_WIDTH, 32, instruction width.
  DEPTH, 4, entry count; power of two, >= 2.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  i_clk  in  1  single clock, rising edge.
  i_arst  in  1  asynchronous, active-low reset.
  i_fetch_valid  in  1  fetch offers an entry.
  o_fetch_ready  out  1  queue accepts an entry.
  i_fetch_instr  in  INSTR_WIDTH  fetched instruction.
  i_fetch_pc  in  ADDR_WIDTH  PC of the fetched instruction.
  i_fetch_pc_target_pred  in  ADDR_WIDTH  BTB predicted target.
  i_fetch_btb_way  in  2  BTB hit way.
  i_fetch_branch_pred_taken  in  1  predictor taken flag.
  i_flush  in  1  mispredict/redirect flush.
  i_dec_ready  in  1  decode accepts the head entry (not stalled).
  o_dec_valid  out  1  head entry is valid.
  o_instruction  out  INSTR_WIDTH  head instruction.
  o_pc  out  ADDR_WIDTH  head PC.
  o_pc_plus4  out  ADDR_WIDTH  head PC + 4.
  o_pc_target_pred  out  ADDR_WIDTH  head predicted target.
  o_btb_way  out  2  head BTB way.
  o_branch_pred_taken  out  1  head taken flag.
  o_count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-003 The queue SHALL be a circular buffer with a write pointer, a read pointer and an occupancy counter.
REQ-004 Push SHALL occur on an edge where i_fetch_valid & o_fetch_ready & !i_flush.
  - Push writes the entry at the write pointer.
  - Push advances the write pointer by 1.
REQ-005 Pop SHALL occur on an edge where o_dec_valid & i_dec_ready & !i_flush.
  - Pop advances the read pointer by 1.
REQ-006 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-007 o_fetch_ready SHALL equal (o_count != DEPTH).
  - It is not gated by a same-cycle pop.
  - It is combinational from registered state only.
REQ-008 o_dec_valid SHALL equal (o_count != 0).
REQ-009 When o_dec_valid is 1, the head outputs SHALL present the entry at the read pointer combinationally (show-ahead, zero-cycle read latency).
REQ-010 o_pc_plus4 SHALL be computed at push as i_fetch_pc + 4, modulo 2^ADDR_WIDTH, and stored with the entry.
REQ-011 When o_dec_valid is 0, outputs SHALL be driven as a bubble:
  - o_instruction = 32'h0000_0013 (NOP).
  - o_pc, o_pc_plus4, o_pc_target_pred, o_btb_way and o_branch_pred_taken = 0.
REQ-012 Counter update SHALL be:
  - push only: o_count + 1.
  - pop only: o_count - 1.
  - push and pop on the same edge: o_count unchanged, both pointers advance.
  - neither: unchanged.
REQ-013 Latency SHALL be: an entry pushed at edge N is visible with o_dec_valid = 1 after edge N (push-to-head latency 1 cycle when empty).
REQ-014 i_flush SHALL take priority over everything on the same edge:
  - both pointers and o_count go to 0.
  - same-cycle push and pop are discarded.
REQ-015 The queue SHALL be empty after a flush, with o_dec_valid = 0 on the next cycle.
REQ-016 Pushes while full SHALL never occur and SHALL never corrupt state, because o_fetch_ready = 0.
REQ-017 A pop while empty SHALL never occur, because o_dec_valid = 0.
REQ-018 Entry storage SHALL only be written on push; storage contents are not reset.

Reset
REQ-019 When i_arst is 0, pointers and o_count SHALL clear to 0 immediately, independent of i_clk.
REQ-020 During and after reset, outputs SHALL be:
  - o_dec_valid = 0, o_fetch_ready = 1, o_count = 0.
  - head outputs per REQ-011.
REQ-021 Reset asserted mid-operation SHALL discard all entries; no entry SHALL reappear after release.
REQ-022 The first push SHALL be accepted on the first rising edge after i_arst returns to 1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Fill/drain: i_dec_ready = 0, push PCs 0x1000, 0x1004, 0x1008, 0x100C.
    -> o_count = 4 and o_fetch_ready = 0.
    -> Then i_dec_ready = 1: PCs pop in order with o_pc_plus4 = 0x1004..0x1010, then o_dec_valid = 0 and o_instruction = 0x00000013.
  - Wrap-around: 10 pushes and pops interleaved, holding o_count at 1-3.
    -> Order and payload (instr, target_pred, btb_way, taken) are preserved across the pointer wrap.
  - Simultaneous push and pop at o_count = 2.
    -> o_count stays 2.
    -> The head advances to the next entry.
    -> The new entry appears last.
  - Flush with push, pop and full queue on the same edge.
    -> Next cycle o_count = 0 and o_dec_valid = 0.
    -> The pushed entry is never presented.
  - PC overflow: push i_fetch_pc = 0xFFFF_FFFF_FFFF_FFFC.
    -> o_pc_plus4 = 0.
  - Async reset with 3 entries queued, asserted between clock edges.
    -> o_count = 0 and o_dec_valid = 0 immediately.
    -> After release, a push of PC 0x2000 appears next cycle as the head.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode with
// show-ahead head outputs, flush priority and a NOP bubble when empty.
module instr_fetch_queue #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  input  logic                       i_fetch_valid,
  output logic                       o_fetch_ready,
  input  logic [INSTR_WIDTH-1:0]     i_fetch_instr,
  input  logic [ADDR_WIDTH-1:0]      i_fetch_pc,
  input  logic [ADDR_WIDTH-1:0]      i_fetch_pc_target_pred,
  input  logic [1:0]                 i_fetch_btb_way,
  input  logic                       i_fetch_branch_pred_taken,
  input  logic                       i_flush,
  input  logic                       i_dec_ready,
  output logic                       o_dec_valid,
  output logic [INSTR_WIDTH-1:0]     o_instruction,
  output logic [ADDR_WIDTH-1:0]      o_pc,
  output logic [ADDR_WIDTH-1:0]      o_pc_plus4,
  output logic [ADDR_WIDTH-1:0]      o_pc_target_pred,
  output logic [1:0]                 o_btb_way,
  output logic                       o_branch_pred_taken,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  target_pred;
    logic [1:0]             btb_way;
    logic                   taken;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign o_fetch_ready = (count != CNT_W'(DEPTH));
  assign o_dec_valid   = (count != '0);
  assign o_count       = count;

  assign push = i_fetch_valid & o_fetch_ready & ~i_flush;
  assign pop  = o_dec_valid & i_dec_ready & ~i_flush;

  // DEPTH is a power of two, so pointer overflow is the wrap to 0.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by count alone, so stale
  // contents are never observable and the array can map onto plain flops/RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{instr:       i_fetch_instr,
                       pc:          i_fetch_pc,
                       pc_plus4:    i_fetch_pc + ADDR_WIDTH'(4),
                       target_pred: i_fetch_pc_target_pred,
                       btb_way:     i_fetch_btb_way,
                       taken:       i_fetch_branch_pred_taken};
    end
  end

  assign head = mem[rd_ptr];

  // NOTE: every output gets a bubble default first so no path infers a latch.
  always_comb begin
    o_instruction       = NOP;
    o_pc                = '0;
    o_pc_plus4          = '0;
    o_pc_target_pred    = '0;
    o_btb_way           = '0;
    o_branch_pred_taken = 1'b0;
    if (o_dec_valid) begin
      o_instruction       = head.instr;
      o_pc                = head.pc;
      o_pc_plus4          = head.pc_plus4;
      o_pc_target_pred    = head.target_pred;
      o_btb_way           = head.btb_way;
      o_branch_pred_taken = head.taken;
    end
  end

endmodule
